// File: rtl/cu_pkg.sv
// Shared types and address-split helpers for the vertex cache reuse engine.
package cu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOOKUP    = 3'd1,
    ST_MISS_REQ  = 3'd2,
    ST_MISS_WAIT = 3'd3,
    ST_FILL      = 3'd4,
    ST_RESP      = 3'd5,
    ST_FLUSH     = 3'd6
  } cu_state_e;

  // Byte-offset bits within one cache line.
  function automatic int cu_offset_w(input int line_w);
    return $clog2(line_w / 8);
  endfunction

  // Set-index bits of the direct-mapped array.
  function automatic int cu_index_w(input int num_sets);
    return $clog2(num_sets);
  endfunction

  // Tag bits: whatever remains of the byte address above offset and index.
  function automatic int cu_tag_w(input int addr_w, input int line_w, input int num_sets);
    return addr_w - cu_offset_w(line_w) - cu_index_w(num_sets);
  endfunction

endpackage

// File: rtl/cu_vertex_cache_array.sv
// Direct-mapped tag/valid/data store: one synchronous read port, one write
// port, and a single-cycle clear of every valid bit (tags and data are kept).
module cu_vertex_cache_array
  import cu_pkg::*;
#(
  parameter int NUM_SETS = 64,
  parameter int TAG_W    = 51,
  parameter int LINE_W   = 1024,
  localparam int INDEX_W = cu_index_w(NUM_SETS)
) (
  input  logic               clock,
  input  logic               rst_in,
  input  logic               clr_in,
  input  logic               rd_en_in,
  input  logic [INDEX_W-1:0] rd_idx_in,
  input  logic               wr_en_in,
  input  logic [INDEX_W-1:0] wr_idx_in,
  input  logic [TAG_W-1:0]   wr_tag_in,
  input  logic [LINE_W-1:0]  wr_data_in,
  output logic               rd_valid_out,
  output logic [TAG_W-1:0]   rd_tag_out,
  output logic [LINE_W-1:0]  rd_data_out
);

  logic [NUM_SETS-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]    tag_mem  [NUM_SETS];
  logic [LINE_W-1:0]   data_mem [NUM_SETS];

  logic                rd_valid_q, rd_valid_d;
  logic [TAG_W-1:0]    rd_tag_q, rd_tag_d;
  logic [LINE_W-1:0]   rd_data_q, rd_data_d;

  // Next valid vector: clear wins, otherwise a write marks its set valid.
  always_comb begin
    valid_d = valid_q;
    if (clr_in) begin
      valid_d = '0;
    end else if (wr_en_in) begin
      valid_d[wr_idx_in] = 1'b1;
    end
  end

  // Read port captures the addressed set; holds its value when not enabled.
  always_comb begin
    rd_valid_d = rd_valid_q;
    rd_tag_d   = rd_tag_q;
    rd_data_d  = rd_data_q;
    if (rd_en_in) begin
      rd_valid_d = valid_q[rd_idx_in];
      rd_tag_d   = tag_mem[rd_idx_in];
      rd_data_d  = data_mem[rd_idx_in];
    end
  end

  // Valid bits and read registers, cleared by reset.
  always_ff @(posedge clock) begin
    if (rst_in) begin
      valid_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_tag_q   <= '0;
      rd_data_q  <= '0;
    end else begin
      valid_q    <= valid_d;
      rd_valid_q <= rd_valid_d;
      rd_tag_q   <= rd_tag_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Tag and data storage carry no reset; the valid bit qualifies them.
  always_ff @(posedge clock) begin
    if (wr_en_in) begin
      tag_mem[wr_idx_in]  <= wr_tag_in;
      data_mem[wr_idx_in] <= wr_data_in;
    end
  end

  assign rd_valid_out = rd_valid_q;
  assign rd_tag_out   = rd_tag_q;
  assign rd_data_out  = rd_data_q;

endmodule

// File: rtl/cu_vertex_cache_reuse_engine.sv
// Single-outstanding direct-mapped line cache for vertex fetch reuse.
// Handshakes: a transfer happens on a clock edge where valid and ready are
// both 1; valid, once raised, holds with stable payload until that edge.
// Responses are a one-cycle resp_valid_out pulse with no back-pressure.
module cu_vertex_cache_reuse_engine
  import cu_pkg::*;
#(
  parameter int NUM_SETS = 64,
  parameter int ADDR_W   = 64,
  parameter int LINE_W   = 1024,
  parameter int ID_W     = 8
) (
  input  logic              clock,
  input  logic              rst_in,
  input  logic              enabled_in,
  input  logic              flush_in,
  input  logic              req_valid_in,
  output logic              req_ready_out,
  input  logic [ADDR_W-1:0] req_addr_in,
  input  logic [ID_W-1:0]   req_id_in,
  output logic              miss_valid_out,
  input  logic              miss_ready_in,
  output logic [ADDR_W-1:0] miss_addr_out,
  output logic [ID_W-1:0]   miss_id_out,
  input  logic              fill_valid_in,
  input  logic [ID_W-1:0]   fill_id_in,
  input  logic [LINE_W-1:0] fill_data_in,
  output logic              resp_valid_out,
  output logic [ID_W-1:0]   resp_id_out,
  output logic [LINE_W-1:0] resp_data_out,
  output logic              resp_hit_out,
  output logic [31:0]       hit_count_out,
  output logic [31:0]       miss_count_out
);

  localparam int OFFSET_W = cu_offset_w(LINE_W);
  localparam int INDEX_W  = cu_index_w(NUM_SETS);
  localparam int TAG_W    = cu_tag_w(ADDR_W, LINE_W, NUM_SETS);
  localparam int LA_W     = ADDR_W - OFFSET_W;  // line address = {tag, index}

  cu_state_e         state_q, state_d;
  logic [LA_W-1:0]   line_addr_q, line_addr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              flush_pend_q, flush_pend_d;
  logic              miss_valid_q, miss_valid_d;
  logic [ADDR_W-1:0] miss_addr_q, miss_addr_d;
  logic [ID_W-1:0]   miss_id_q, miss_id_d;
  logic [LINE_W-1:0] fill_line_q, fill_line_d;
  logic              resp_valid_q, resp_valid_d;
  logic [ID_W-1:0]   resp_id_q, resp_id_d;
  logic [LINE_W-1:0] resp_data_q, resp_data_d;
  logic              resp_hit_q, resp_hit_d;
  logic [31:0]       hit_cnt_q, hit_cnt_d;
  logic [31:0]       miss_cnt_q, miss_cnt_d;

  logic              accept;
  logic              arr_rd_valid;
  logic [TAG_W-1:0]  arr_rd_tag;
  logic [LINE_W-1:0] arr_rd_data;
  logic              unused_offset;

  // Byte-offset bits never matter: the cache deals in whole lines.
  assign unused_offset = ^req_addr_in[OFFSET_W-1:0];

  // A pending or live flush, reset, or a busy FSM all block acceptance.
  assign req_ready_out = (state_q == ST_IDLE) && enabled_in && !flush_in
                         && !flush_pend_q && !rst_in;
  assign accept        = req_valid_in && req_ready_out;

  cu_vertex_cache_array #(
    .NUM_SETS (NUM_SETS),
    .TAG_W    (TAG_W),
    .LINE_W   (LINE_W)
  ) u_array (
    .clock        (clock),
    .rst_in       (rst_in),
    .clr_in       (state_q == ST_FLUSH),
    .rd_en_in     (accept),
    .rd_idx_in    (req_addr_in[OFFSET_W +: INDEX_W]),
    .wr_en_in     (state_q == ST_FILL),
    .wr_idx_in    (line_addr_q[INDEX_W-1:0]),
    .wr_tag_in    (line_addr_q[LA_W-1:INDEX_W]),
    .wr_data_in   (fill_line_q),
    .rd_valid_out (arr_rd_valid),
    .rd_tag_out   (arr_rd_tag),
    .rd_data_out  (arr_rd_data)
  );

  // Next-state and registered-output logic for the request FSM.
  always_comb begin
    state_d      = state_q;
    line_addr_d  = line_addr_q;
    id_d         = id_q;
    flush_pend_d = flush_pend_q;
    miss_valid_d = miss_valid_q;
    miss_addr_d  = miss_addr_q;
    miss_id_d    = miss_id_q;
    fill_line_d  = fill_line_q;
    resp_valid_d = 1'b0;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
    resp_hit_d   = resp_hit_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;

    // A flush seen while busy is remembered until the FSM is idle again.
    if (flush_in && (state_q != ST_IDLE) && (state_q != ST_FLUSH)) begin
      flush_pend_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (flush_in || flush_pend_q) begin
          flush_pend_d = 1'b0;
          state_d      = ST_FLUSH;
        end else if (accept) begin
          line_addr_d = req_addr_in[ADDR_W-1:OFFSET_W];
          id_d        = req_id_in;
          state_d     = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (arr_rd_valid && (arr_rd_tag == line_addr_q[LA_W-1:INDEX_W])) begin
          resp_valid_d = 1'b1;
          resp_hit_d   = 1'b1;
          resp_id_d    = id_q;
          resp_data_d  = arr_rd_data;
          if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_d = hit_cnt_q + 32'd1;
          state_d      = ST_RESP;
        end else begin
          miss_valid_d = 1'b1;
          miss_addr_d  = {line_addr_q, {OFFSET_W{1'b0}}};
          miss_id_d    = id_q;
          state_d      = ST_MISS_REQ;
        end
      end
      ST_MISS_REQ: begin
        if (miss_ready_in) begin
          miss_valid_d = 1'b0;
          state_d      = ST_MISS_WAIT;
        end
      end
      ST_MISS_WAIT: begin
        if (fill_valid_in && (fill_id_in == id_q)) begin
          fill_line_d = fill_data_in;
          state_d     = ST_FILL;
        end
      end
      ST_FILL: begin
        resp_valid_d = 1'b1;
        resp_hit_d   = 1'b0;
        resp_id_d    = id_q;
        resp_data_d  = fill_line_q;
        if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
        state_d      = ST_RESP;
      end
      ST_RESP:  state_d = ST_IDLE;
      ST_FLUSH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset abandons any in-flight miss.
  always_ff @(posedge clock) begin
    if (rst_in) begin
      state_q      <= ST_IDLE;
      line_addr_q  <= '0;
      id_q         <= '0;
      flush_pend_q <= 1'b0;
      miss_valid_q <= 1'b0;
      miss_addr_q  <= '0;
      miss_id_q    <= '0;
      fill_line_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
      resp_hit_q   <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      line_addr_q  <= line_addr_d;
      id_q         <= id_d;
      flush_pend_q <= flush_pend_d;
      miss_valid_q <= miss_valid_d;
      miss_addr_q  <= miss_addr_d;
      miss_id_q    <= miss_id_d;
      fill_line_q  <= fill_line_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
      resp_hit_q   <= resp_hit_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign miss_valid_out = miss_valid_q;
  assign miss_addr_out  = miss_addr_q;
  assign miss_id_out    = miss_id_q;
  assign resp_valid_out = resp_valid_q;
  assign resp_id_out    = resp_id_q;
  assign resp_data_out  = resp_data_q;
  assign resp_hit_out   = resp_hit_q;
  assign hit_count_out  = hit_cnt_q;
  assign miss_count_out = miss_cnt_q;

endmodule

// File: tb/tb_cu_vertex_cache_reuse_engine.sv
// Directed bench for the vertex cache reuse engine (default parameters:
// 64 sets, 128-byte lines, so index = addr[12:7]).
module tb_cu_vertex_cache_reuse_engine;

  localparam int ADDR_W = 64;
  localparam int LINE_W = 1024;
  localparam int ID_W   = 8;

  // ---------------- clock / reset ----------------
  logic              clock = 1'b0;
  logic              rst_in = 1'b1;
  logic              enabled_in = 1'b1;
  logic              flush_in = 1'b0;
  logic              req_valid_in = 1'b0;
  logic              req_ready_out;
  logic [ADDR_W-1:0] req_addr_in = '0;
  logic [ID_W-1:0]   req_id_in = '0;
  logic              miss_valid_out;
  logic              miss_ready_in = 1'b1;
  logic [ADDR_W-1:0] miss_addr_out;
  logic [ID_W-1:0]   miss_id_out;
  logic              fill_valid_in = 1'b0;
  logic [ID_W-1:0]   fill_id_in = '0;
  logic [LINE_W-1:0] fill_data_in = '0;
  logic              resp_valid_out;
  logic [ID_W-1:0]   resp_id_out;
  logic [LINE_W-1:0] resp_data_out;
  logic              resp_hit_out;
  logic [31:0]       hit_count_out;
  logic [31:0]       miss_count_out;

  always #5 clock = ~clock;

  cu_vertex_cache_reuse_engine dut (
    .clock          (clock),
    .rst_in         (rst_in),
    .enabled_in     (enabled_in),
    .flush_in       (flush_in),
    .req_valid_in   (req_valid_in),
    .req_ready_out  (req_ready_out),
    .req_addr_in    (req_addr_in),
    .req_id_in      (req_id_in),
    .miss_valid_out (miss_valid_out),
    .miss_ready_in  (miss_ready_in),
    .miss_addr_out  (miss_addr_out),
    .miss_id_out    (miss_id_out),
    .fill_valid_in  (fill_valid_in),
    .fill_id_in     (fill_id_in),
    .fill_data_in   (fill_data_in),
    .resp_valid_out (resp_valid_out),
    .resp_id_out    (resp_id_out),
    .resp_data_out  (resp_data_out),
    .resp_hit_out   (resp_hit_out),
    .hit_count_out  (hit_count_out),
    .miss_count_out (miss_count_out)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [ID_W:0]     exp_q[$];       // {hit, id}
  logic [LINE_W-1:0] exp_data_q[$];
  int                cyc = 0;
  int                resp_cnt = 0;
  int                resp_cyc = 0;
  int                miss_hs_cnt = 0;
  int                miss_high_cnt = 0;
  logic [ADDR_W-1:0] miss_addr_seen = '0;
  logic [ID_W-1:0]   miss_id_seen = '0;
  logic              prev_resp = 1'b0;
  int                acc_cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (prev_resp) check("resp_pulse_width", {63'd0, resp_valid_out}, 64'd0);
    prev_resp = resp_valid_out;
    if (miss_valid_out) miss_high_cnt++;
    if (miss_valid_out && miss_ready_in) begin
      miss_hs_cnt++;
      miss_addr_seen = miss_addr_out;
      miss_id_seen   = miss_id_out;
    end
    if (resp_valid_out) begin
      logic [ID_W:0]     e;
      logic [LINE_W-1:0] ed;
      resp_cnt++;
      resp_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_resp_id", {56'd0, resp_id_out}, 64'hFFFF);
      end else begin
        e  = exp_q.pop_front();
        ed = exp_data_q.pop_front();
        check("resp_id", {56'd0, resp_id_out}, {56'd0, e[ID_W-1:0]});
        check("resp_hit", {63'd0, resp_hit_out}, {63'd0, e[ID_W]});
        check("resp_data_eq", {63'd0, resp_data_out == ed}, 64'd1);
      end
    end
  end

  // ---------------- driver tasks (entered/left at posedge+1) ----------------
  function automatic logic [LINE_W-1:0] mk_line(input logic [31:0] seed);
    logic [LINE_W-1:0] l;
    for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = seed + i * 32'h0101_0101;
    return l;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_req(input logic [ADDR_W-1:0] addr, input logic [ID_W-1:0] id);
    int n;
    req_valid_in = 1'b1;
    req_addr_in  = addr;
    req_id_in    = id;
    n = 0;
    @(negedge clock);
    while (!req_ready_out && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) check("req_accept_timeout", 64'd0, 64'd1);
    acc_cyc = cyc;
    @(posedge clock);
    #1 req_valid_in = 1'b0;
  endtask

  task automatic do_fill(input logic [ID_W-1:0] id, input logic [LINE_W-1:0] data);
    fill_valid_in = 1'b1;
    fill_id_in    = id;
    fill_data_in  = data;
    tick(1);
    fill_valid_in = 1'b0;
  endtask

  task automatic wait_resp(input int start);
    int n;
    n = 0;
    while (resp_cnt <= start && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) check("resp_timeout", 64'd0, 64'd1);
    tick(1);
  endtask

  task automatic wait_miss(input int start);
    int n;
    n = 0;
    while (miss_hs_cnt <= start && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) check("miss_timeout", 64'd0, 64'd1);
    tick(1);
  endtask

  task automatic miss_cycle(input logic [ADDR_W-1:0] addr, input logic [ID_W-1:0] id,
                            input logic [LINE_W-1:0] data);
    int ms, rs;
    exp_q.push_back({1'b0, id});
    exp_data_q.push_back(data);
    ms = miss_hs_cnt;
    rs = resp_cnt;
    do_req(addr, id);
    wait_miss(ms);
    check("miss_addr", miss_addr_seen, addr & ~64'h7F);
    check("miss_id", {56'd0, miss_id_seen}, {56'd0, id});
    do_fill(id, data);
    wait_resp(rs);
  endtask

  task automatic hit_req(input logic [ADDR_W-1:0] addr, input logic [ID_W-1:0] id,
                         input logic [LINE_W-1:0] data);
    int rs, mh;
    exp_q.push_back({1'b1, id});
    exp_data_q.push_back(data);
    rs = resp_cnt;
    mh = miss_high_cnt;
    do_req(addr, id);
    wait_resp(rs);
    check("hit_latency", 64'(resp_cyc - acc_cyc), 64'd2);
    check("hit_no_miss_valid", 64'(miss_high_cnt), 64'(mh));
  endtask

  // ---------------- directed stimulus ----------------
  logic [LINE_W-1:0] d1, d2, d3, d4, d5, d6, d7, d8, d9;
  int rs0, ms0;

  initial begin
    d1 = mk_line(32'hD1D1_0000); d2 = mk_line(32'hD2D2_0000);
    d3 = mk_line(32'hD3D3_0000); d4 = mk_line(32'hD4D4_0000);
    d5 = mk_line(32'hD5D5_0000); d6 = mk_line(32'hD6D6_0000);
    d7 = mk_line(32'hD7D7_0000); d8 = mk_line(32'hD8D8_0000);
    d9 = mk_line(32'hD9D9_0000);

    // reset state
    tick(2);
    @(negedge clock);
    check("ready_in_reset", {63'd0, req_ready_out}, 64'd0);
    tick(1);
    rst_in = 1'b0;
    @(negedge clock);
    check("rst_resp_valid", {63'd0, resp_valid_out}, 64'd0);
    check("rst_miss_valid", {63'd0, miss_valid_out}, 64'd0);
    check("rst_hit_count", {32'd0, hit_count_out}, 64'd0);
    check("rst_miss_count", {32'd0, miss_count_out}, 64'd0);
    check("idle_ready", {63'd0, req_ready_out}, 64'd1);
    tick(1);

    // cold miss 0x1000 id 5, miss held under back-pressure, stray fill id 7
    miss_ready_in = 1'b0;
    exp_q.push_back({1'b0, 8'd5});
    exp_data_q.push_back(d1);
    rs0 = resp_cnt;
    do_req(64'h1000, 8'd5);
    tick(3);
    @(negedge clock);
    check("cold_miss_valid_held", {63'd0, miss_valid_out}, 64'd1);
    check("cold_miss_addr", miss_addr_out, 64'h1000);
    check("cold_miss_id", {56'd0, miss_id_out}, 64'd5);
    tick(1);
    miss_ready_in = 1'b1;
    tick(1);
    @(negedge clock);
    check("miss_valid_dropped", {63'd0, miss_valid_out}, 64'd0);
    tick(1);
    do_fill(8'd7, d9);
    tick(3);
    check("stray_fill_no_resp", 64'(resp_cnt), 64'(rs0));
    do_fill(8'd5, d1);
    wait_resp(rs0);
    check("cold_miss_count", {32'd0, miss_count_out}, 64'd1);
    check("cold_hit_count", {32'd0, hit_count_out}, 64'd0);

    // reuse: 0x1040 is in the same 128-byte line as 0x1000
    hit_req(64'h1040, 8'd9, d1);
    check("reuse_hit_count", {32'd0, hit_count_out}, 64'd1);

    // conflict on set 0: 0x0000, 0x2000, 0x0000 all miss
    miss_cycle(64'h0000, 8'd1, d2);
    miss_cycle(64'h2000, 8'd2, d3);
    miss_cycle(64'h0000, 8'd3, d4);
    check("conflict_miss_count", {32'd0, miss_count_out}, 64'd4);

    // flush with a simultaneous request; previous hit address then misses
    hit_req(64'h1000, 8'd8, d1);
    rs0 = resp_cnt;
    flush_in     = 1'b1;
    req_valid_in = 1'b1;
    req_addr_in  = 64'h0000;
    req_id_in    = 8'd4;
    @(negedge clock);
    check("flush_blocks_ready", {63'd0, req_ready_out}, 64'd0);
    tick(1);
    flush_in     = 1'b0;
    req_valid_in = 1'b0;
    tick(4);
    check("flush_req_dropped", 64'(resp_cnt), 64'(rs0));
    miss_cycle(64'h1000, 8'd6, d5);

    // flush raised while busy is serviced once idle
    exp_q.push_back({1'b0, 8'd10});
    exp_data_q.push_back(d6);
    ms0 = miss_hs_cnt;
    rs0 = resp_cnt;
    do_req(64'h0080, 8'd10);
    wait_miss(ms0);
    flush_in = 1'b1;
    tick(1);
    flush_in = 1'b0;
    do_fill(8'd10, d6);
    wait_resp(rs0);
    miss_cycle(64'h0080, 8'd11, d7);

    // enabled dropped mid-transaction: transaction completes, new ones blocked
    exp_q.push_back({1'b0, 8'd13});
    exp_data_q.push_back(d8);
    ms0 = miss_hs_cnt;
    rs0 = resp_cnt;
    do_req(64'h4000, 8'd13);
    enabled_in = 1'b0;
    wait_miss(ms0);
    do_fill(8'd13, d8);
    wait_resp(rs0);
    rs0 = resp_cnt;
    req_valid_in = 1'b1;
    req_addr_in  = 64'h1000;
    req_id_in    = 8'd15;
    @(negedge clock);
    check("disabled_ready", {63'd0, req_ready_out}, 64'd0);
    tick(4);
    check("disabled_no_resp", 64'(resp_cnt), 64'(rs0));
    req_valid_in = 1'b0;
    enabled_in   = 1'b1;
    check("pre_reset_hit_count", {32'd0, hit_count_out}, 64'd2);
    check("pre_reset_miss_count", {32'd0, miss_count_out}, 64'd8);

    // reset while waiting for a fill
    ms0 = miss_hs_cnt;
    do_req(64'h3000, 8'd5);
    wait_miss(ms0);
    rst_in = 1'b1;
    tick(1);
    rst_in = 1'b0;
    @(negedge clock);
    check("mid_rst_miss_valid", {63'd0, miss_valid_out}, 64'd0);
    check("mid_rst_miss_addr", miss_addr_out, 64'd0);
    check("mid_rst_miss_id", {56'd0, miss_id_out}, 64'd0);
    check("mid_rst_resp_id", {56'd0, resp_id_out}, 64'd0);
    check("mid_rst_resp_hit", {63'd0, resp_hit_out}, 64'd0);
    check("mid_rst_resp_data_zero", {63'd0, resp_data_out == '0}, 64'd1);
    check("mid_rst_hit_count", {32'd0, hit_count_out}, 64'd0);
    check("mid_rst_miss_count", {32'd0, miss_count_out}, 64'd0);
    tick(1);
    rs0 = resp_cnt;
    do_fill(8'd5, d9);
    tick(5);
    check("post_rst_fill_ignored", 64'(resp_cnt), 64'(rs0));
    miss_cycle(64'h1000, 8'd14, d9);
    check("post_rst_miss_count", {32'd0, miss_count_out}, 64'd1);
    check("post_rst_hit_count", {32'd0, hit_count_out}, 64'd0);

    tick(3);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
    $finish;
  end

  // absolute bound on the run
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cu_vertex_cache_reuse_engine.md
CU_VERTEX_CACHE_REUSE_ENGINE -- requirements
Module: cu_vertex_cache_reuse_engine

Interface
REQ-001 Parameter NUM_SETS, default 64, meaning direct-mapped line count; power of two, >=2.
REQ-002 Parameter ADDR_W, default 64, meaning byte-address width.
REQ-003 Parameter LINE_W, default 1024, meaning cache-line data width in bits (128 bytes).
REQ-004 Parameter ID_W, default 8, meaning request-tag width.
REQ-005 Ports, in order:
- clock  in  1  sole clock; one clock; reset is synchronous and active-high.
- rst_in  in  1  synchronous active-high reset.
- enabled_in  in  1  gates request acceptance.
- flush_in  in  1  invalidate all lines.
- req_valid_in / req_ready_out  in/out  1  request handshake.
- req_addr_in  in  ADDR_W  byte address.
- req_id_in  in  ID_W  request tag.
- miss_valid_out / miss_ready_in  out/in  1  miss handshake.
- miss_addr_out  out  ADDR_W  line-aligned miss address.
- miss_id_out  out  ID_W  tag of the missing request.
- fill_valid_in  in  1  fill data valid.
- fill_id_in  in  ID_W  fill tag.
- fill_data_in  in  LINE_W  fill line.
- resp_valid_out  out  1  one-cycle response pulse.
- resp_id_out  out  ID_W  response tag.
- resp_data_out  out  LINE_W  response line.
- resp_hit_out  out  1  response was a hit.
- hit_count_out / miss_count_out  out  32  statistics.

Function
REQ-006 The block SHALL split the address into offset (log2(LINE_W/8) bits), index (log2(NUM_SETS) bits), and tag (remaining bits).
REQ-007 The block SHALL store per set a valid bit, a tag, and a LINE_W line.
REQ-008 The FSM SHALL have states IDLE, LOOKUP, MISS_REQ, MISS_WAIT, FILL, RESP, FLUSH.
REQ-009 req_ready_out SHALL be 1 only in IDLE with enabled_in=1 and flush_in=0.
REQ-010 IDLE transitions:
- An accepted request SHALL latch addr/id and go to LOOKUP.
- flush_in=1 SHALL go to FLUSH; flush has priority over a simultaneous request, which is not accepted.
REQ-011 LOOKUP transitions:
- Valid and tag match SHALL go to RESP with resp_hit_out=1 and data from the array.
- Otherwise SHALL go to MISS_REQ.
- Hit latency SHALL be 2 cycles from acceptance to resp_valid_out.
REQ-012 MISS_REQ SHALL hold miss_valid_out=1 with the line-aligned address and latched id until miss_ready_in=1, then go to MISS_WAIT.
REQ-013 MISS_WAIT SHALL ignore fills whose fill_id_in differs from the latched id; a matching fill SHALL go to FILL.
REQ-014 FILL SHALL write the line, tag, and valid=1, then go to RESP with resp_hit_out=0 and the fill data.
REQ-015 RESP SHALL assert resp_valid_out for exactly one cycle, then return to IDLE.
REQ-016 FLUSH SHALL clear all valid bits in one cycle and return to IDLE; tags and data are not cleared.
REQ-017 flush_in asserted outside IDLE SHALL be serviced on the next IDLE cycle.
REQ-018 hit_count_out SHALL increment on each hit response and miss_count_out on each miss response; both SHALL saturate at 32'hFFFFFFFF.
REQ-019 Deasserting enabled_in mid-transaction SHALL NOT abort the transaction; it only blocks new acceptance.
REQ-020 Outputs SHALL be registered; no combinational path from any input to any output except req_ready_out.

Reset
REQ-021 On rst_in=1 at a clock edge:
- the FSM SHALL go to IDLE;
- all valid bits, counters, resp_valid_out, miss_valid_out, resp_hit_out, and all id/addr/data outputs SHALL go to 0;
- any in-flight miss SHALL be abandoned, and a later fill SHALL be ignored.
REQ-022 req_ready_out SHALL be 0 while rst_in=1.

Structure
REQ-023 The state enum and the address-split field widths SHALL reside in CU_PKG.
REQ-024 The tag/valid/data storage SHALL be one sub-module, cu_vertex_cache_array (1 read port, 1 write port, synchronous read, single-cycle valid clear).

Verification
REQ-025 Cold miss: request addr 0x1000 id 5 -> miss_addr_out=0x1000 id 5; fill id 5 data D -> resp id 5, data D, hit=0, miss_count=1.
REQ-026 Reuse: same address 0x1040 after fill of 0x1000 -> resp 2 cycles after acceptance, hit=1, no miss_valid_out, hit_count=1.
REQ-027 Conflict: 0x0000 then 0x2000 with NUM_SETS=64 (same index) -> second misses; a third request to 0x0000 misses again.
REQ-028 Stray fill: fill id 7 while waiting on id 5 -> ignored, stays MISS_WAIT; fill id 5 completes.
REQ-029 Flush plus simultaneous request -> request not accepted, all lines invalid; a repeat of a previous hit address misses.
REQ-030 Reset mid-MISS_WAIT -> all outputs 0, counters 0; a subsequent fill produces no response.
